coin_return: RTL and testbench

Refund dispense controller sitting directly downstream of the refund-release detector. When that detector's `isdown` output rises (refund switch released), this block snapshots the accumulated credit, clears the credit register, and returns the credit as a sequence of coins, largest denomination first, using a valid/ack handshake with the coin-return mechanism. It is busy until the last coin is acknowledged, and it ignores further refund requests while busy.

---
 rtl/coin_return_if.sv | 26 ++
 rtl/coin_return.sv | 135 +++++++++++++
 tb/tb_coin_return.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_if.sv
// Refund dispense bus: refund request and credit snapshot from upstream,
// coin handshake with the coin-return mechanism, and status back out.
// master = coin_return controller, slave = environment (detector/mechanism).
interface coin_return_if #(
    parameter int CW = 8
);
    logic          isdown;
    logic [CW-1:0] credit;
    logic          credit_clr;
    logic          coin_valid;
    logic [1:0]    coin_sel;
    logic          coin_ack;
    logic          busy;
    logic          done;
    logic          fault;

    modport master (
        input  isdown, credit, coin_ack,
        output credit_clr, coin_valid, coin_sel, busy, done, fault
    );

    modport slave (
        output isdown, credit, coin_ack,
        input  credit_clr, coin_valid, coin_sel, busy, done, fault
    );
endinterface

// File: rtl/coin_return.sv
// coin_return: snapshots credit on a refund request and pays it back as
// coins, largest first, over a valid/ack handshake.
// Optional ack watchdog: define COIN_RETURN_TIMEOUT_EN to enable the
// FAULT state after TIMEOUT un-acked DISPENSE cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a rising isdown
// LOAD     | credit captured in rem, credit_clr pulsed
// DISPENSE | coin_valid up, coin chosen from rem, waiting for coin_ack
// DONE     | one-cycle done pulse
// FAULT    | ack watchdog expired; held until reset (macro only)
module coin_return #(
    parameter int CW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    coin_return_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_DISPENSE = 3'd2,
        S_DONE     = 3'd3
`ifdef COIN_RETURN_TIMEOUT_EN
        , S_FAULT  = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          isdown_q;
    logic          trigger;
    logic [1:0]    sel_raw;
    logic [CW-1:0] coin_val;

    assign trigger = bus.isdown && !isdown_q && (state_q == S_IDLE);

    // Greedy coin choice from the remaining balance; stable while rem holds.
    always_comb begin
        sel_raw  = 2'b01;
        coin_val = CW'(1);
        if (rem_q >= CW'(5)) begin
            sel_raw  = 2'b11;
            coin_val = CW'(5);
        end else if (rem_q >= CW'(2)) begin
            sel_raw  = 2'b10;
            coin_val = CW'(2);
        end
    end

`ifdef COIN_RETURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q;

    // Ack watchdog: restarts on DISPENSE entry and on every ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == S_LOAD) begin
            cnt_q <= '0;
        end else if (state_q == S_DISPENSE) begin
            if (bus.coin_ack) cnt_q <= '0;
            else              cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // State, balance and request-edge registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            isdown_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            isdown_q <= bus.isdown;
        end
    end

    // Next-state and balance update.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    rem_d   = bus.credit;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (rem_q == '0) ? S_DONE : S_DISPENSE;
            end
            S_DISPENSE: begin
                if (bus.coin_ack) begin
                    rem_d = rem_q - coin_val;
                    if (rem_d == '0) state_d = S_DONE;
                end
`ifdef COIN_RETURN_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef COIN_RETURN_TIMEOUT_EN
            S_FAULT: begin
                state_d = S_FAULT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state and balance.
    always_comb begin
        bus.credit_clr = (state_q == S_LOAD);
        bus.coin_valid = (state_q == S_DISPENSE);
        bus.coin_sel   = (state_q == S_DISPENSE) ? sel_raw : 2'b00;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = (state_q == S_DONE);
`ifdef COIN_RETURN_TIMEOUT_EN
        bus.fault      = (state_q == S_FAULT);
`else
        bus.fault      = 1'b0;
`endif
    end
endmodule

// File: tb/tb_coin_return.sv
// Bench for coin_return: directed table of refunds, randomized refunds
// against a greedy-change model, reset abort, and (with
// COIN_RETURN_TIMEOUT_EN) the ack watchdog.
module tb_coin_return;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    coin_return_if #(.CW(8)) bus ();

    coin_return #(.CW(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] credit;
        int         dly;      // ack delay per coin, -1 = random 0..3
        bit         second;   // extra isdown rising edge during DISPENSE
        int         q, d, n;  // expected coin counts
        int         done_at;  // expected done cycle after trigger, -1 = skip
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // One refund: trigger at the posedge after the first negedge, then
    // monitor every cycle (sampled at negedge) until a few cycles past done.
    task automatic run_refund(input string tag, input logic [7:0] c, input int dly,
                              input bit second, input int eq, input int ed,
                              input int en, input int edone);
        int nq = 0, nd = 0, nn = 0, nclr = 0, ndone = 0;
        int clr_at = 0, done_at = 0, sel_err = 0, busy_err = 0;
        int w = 0, cur_dly = 0, last_val = 5;
        bit waiting = 0;
        logic [1:0] hold_sel = 2'b00;
        bit busy_exp;
        @(negedge clk);
        bus.credit   = c;
        bus.isdown   = 1'b1;
        bus.coin_ack = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            if (bus.credit_clr) begin nclr++; clr_at = cyc; end
            if (bus.done) begin ndone++; if (done_at == 0) done_at = cyc; end
            busy_exp = (done_at == 0) || (cyc == done_at);
            if (bus.busy != busy_exp) busy_err++;
            if (bus.coin_valid) begin
                if (!waiting) begin
                    waiting  = 1;
                    w        = 0;
                    hold_sel = bus.coin_sel;
                    cur_dly  = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                end else if (bus.coin_sel != hold_sel) begin
                    sel_err++;
                end
                if (w == cur_dly) begin
                    int v;
                    bus.coin_ack = 1'b1;
                    waiting = 0;
                    case (bus.coin_sel)
                        2'b11:   begin nq++; v = 5; end
                        2'b10:   begin nd++; v = 2; end
                        2'b01:   begin nn++; v = 1; end
                        default: begin sel_err++; v = 9; end
                    endcase
                    if (v > last_val) sel_err++;
                    last_val = v;
                end else begin
                    bus.coin_ack = 1'b0;
                    w++;
                end
            end else begin
                bus.coin_ack = 1'b0;
                if (bus.coin_sel != 2'b00) sel_err++;
            end
            bus.isdown = (cyc == 1) || (second && cyc == 3);
            bus.credit = 8'($urandom);
            if (done_at != 0 && cyc >= done_at + 3) break;
        end
        bus.isdown   = 1'b0;
        bus.coin_ack = 1'b0;
        check({tag, " quarters"}, nq, eq);
        check({tag, " dimes"}, nd, ed);
        check({tag, " nickels"}, nn, en);
        check({tag, " clr_count"}, nclr, 1);
        check({tag, " clr_cycle"}, clr_at, 1);
        check({tag, " done_count"}, ndone, 1);
        if (edone >= 0) check({tag, " done_cycle"}, done_at, edone);
        check({tag, " sel_errors"}, sel_err, 0);
        check({tag, " busy_errors"}, busy_err, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " credit_clr"}, int'(bus.credit_clr), 0);
        check({tag, " coin_valid"}, int'(bus.coin_valid), 0);
        check({tag, " coin_sel"}, int'(bus.coin_sel), 0);
        check({tag, " busy"}, int'(bus.busy), 0);
        check({tag, " done"}, int'(bus.done), 0);
        check({tag, " fault"}, int'(bus.fault), 0);
    endtask

    initial begin
        int c, vq, vd, vn, idle_err;

        vecs[0] = '{8'd8,   0, 1'b0,  1, 1, 1,  5};
        vecs[1] = '{8'd4,   3, 1'b0,  0, 2, 0, 10};
        vecs[2] = '{8'd0,   0, 1'b0,  0, 0, 0,  2};
        vecs[3] = '{8'd15,  0, 1'b1,  3, 0, 0,  5};
        vecs[4] = '{8'd1,   1, 1'b0,  0, 0, 1,  4};
        vecs[5] = '{8'd255, 0, 1'b0, 51, 0, 0, 53};
        vecs[6] = '{8'd7,   2, 1'b0,  1, 1, 0,  8};
        vecs[7] = '{8'd3,   0, 1'b0,  0, 1, 1,  4};
        vecs[8] = '{8'd9,   1, 1'b0,  1, 2, 0,  8};

        reset        = 1'b0;
        bus.isdown   = 1'b0;
        bus.credit   = '0;
        bus.coin_ack = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("after_reset");

        foreach (vecs[i])
            run_refund($sformatf("vec%0d", i), vecs[i].credit, vecs[i].dly,
                       vecs[i].second, vecs[i].q, vecs[i].d, vecs[i].n,
                       vecs[i].done_at);

        for (int k = 0; k < 25; k++) begin
            c  = int'($urandom_range(0, 255));
            vq = c / 5;
            vd = (c % 5) / 2;
            vn = (c % 5) % 2;
            run_refund($sformatf("rnd%0d_c%0d", k, c), 8'(c), -1,
                       1'($urandom), vq, vd, vn, -1);
        end

        // Reset after the first quarter of 15 units.
        @(negedge clk);
        bus.credit   = 8'd15;
        bus.isdown   = 1'b1;
        bus.coin_ack = 1'b1;
        @(negedge clk);              // cycle 1: LOAD
        bus.isdown = 1'b0;
        @(negedge clk);              // cycle 2: first quarter, acked
        check("mid_valid_before_reset", int'(bus.coin_valid), 1);
        @(negedge clk);              // cycle 3: second quarter requested
        check("mid_sel_before_reset", int'(bus.coin_sel), 3);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        idle_err = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy || bus.coin_valid || bus.credit_clr || bus.done) idle_err++;
        end
        check("post_reset_idle", idle_err, 0);
        bus.coin_ack = 1'b0;

`ifdef COIN_RETURN_TIMEOUT_EN
        @(negedge clk);
        bus.credit = 8'd1;
        bus.isdown = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            bus.isdown = 1'b0;
            if (cyc == 16) begin
                check("to_valid_c16", int'(bus.coin_valid), 1);
                check("to_fault_c16", int'(bus.fault), 0);
            end
            if (cyc == 17) begin
                check("to_fault_c17", int'(bus.fault), 1);
                check("to_valid_c17", int'(bus.coin_valid), 0);
            end
            if (cyc == 30) begin
                check("to_busy_c30", int'(bus.busy), 1);
                check("to_fault_c30", int'(bus.fault), 1);
            end
        end
        reset = 1'b0;
        #1;
        check_all_zero("to_reset");
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
